// File: rtl/demux16_pkg.sv
// demux16_pkg: shared constants and word/select types for the demux16 router slice.
package demux16_pkg;
   localparam int WIDTH_DEF = 16;
   localparam int NOUT_DEF  = 8;
   typedef logic [WIDTH_DEF-1:0] word_t;
   typedef logic [2:0]           sel_t;
endpackage

// File: rtl/demux16_slot.sv
// demux16_slot: one-entry output slot; a push wins over a pop so push+pop reloads without a bubble.
module demux16_slot
   import demux16_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid
);
   logic [WIDTH-1:0] r_data;
   logic             r_valid;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= i_push | (r_valid & ~i_pop);
         if (i_push) r_data <= i_data;
      end
   end
   assign o_data  = r_data;
   assign o_valid = r_valid;
endmodule

// File: rtl/demux16_router.sv
// demux16_router: registered 1-to-NOUT word demultiplexer with per-channel valid/ready slots.
// Optional broadcast input i_in_bcast is enabled by defining DEMUX16_BROADCAST_EN.
module demux16_router
   import demux16_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int NOUT  = NOUT_DEF,
   parameter int SELW  = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [WIDTH-1:0]      i_in_data,
   input  logic [SELW-1:0]       i_in_sel,
   input  logic                  i_in_valid,
`ifdef DEMUX16_BROADCAST_EN
   input  logic                  i_in_bcast,
`endif
   output logic                  o_in_ready,
   output logic [NOUT*WIDTH-1:0] o_out_data,
   output logic [NOUT-1:0]       o_out_valid,
   input  logic [NOUT-1:0]       i_out_ready,
   output logic                  o_err_sel
);
   logic                 w_bcast;
   logic                 w_in_range;
   logic                 w_accept;
   logic [NOUT-1:0]      w_slot_ok;
   logic [2**SELW-1:0]   w_sel_ok;
   logic [NOUT-1:0]      w_push;
   logic [NOUT-1:0]      w_pop;
   logic                 r_err;
`ifdef DEMUX16_BROADCAST_EN
   assign w_bcast = i_in_bcast;
`else
   assign w_bcast = 1'b0;
`endif
   assign w_slot_ok  = ~o_out_valid | i_out_ready;
   assign w_pop      = o_out_valid & i_out_ready;
   assign w_in_range = int'(i_in_sel) < NOUT;
   // Unused select codes read as always-ready so stray words are swallowed.
   always_comb begin
      w_sel_ok = '1;
      for (int k = 0; k < NOUT; k++) w_sel_ok[k] = w_slot_ok[k];
   end
   assign o_in_ready = w_bcast ? &w_slot_ok : w_sel_ok[i_in_sel];
   assign w_accept   = i_in_valid && o_in_ready;
   always_comb begin
      w_push = '0;
      for (int k = 0; k < NOUT; k++)
         w_push[k] = w_accept && (w_bcast || (w_in_range && int'(i_in_sel) == k));
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_err <= 1'b0;
      else        r_err <= w_accept && !w_bcast && !w_in_range;
   end
   assign o_err_sel = r_err;
   for (genvar g = 0; g < NOUT; g++) begin : g_slot
      demux16_slot #(.WIDTH(WIDTH)) u_slot (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_push  (w_push[g]),
         .i_pop   (w_pop[g]),
         .i_data  (i_in_data),
         .o_data  (o_out_data[g*WIDTH +: WIDTH]),
         .o_valid (o_out_valid[g])
      );
   end
endmodule

// File: tb/tb_demux16_router.sv
// tb_demux16_router: random and directed checks of demux16_router (NOUT=8 and NOUT=5) against a slot-array model.
module tb_demux16_router;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [15:0]  tb_data = '0;
   logic [2:0]   tb_sel = '0;
   logic         tb_valid = 1'b0;
   logic         tb_bcast = 1'b0;
   logic [7:0]   tb_ordy = '0;
   logic         rdy8, rdy5, err8, err5;
   logic [127:0] data8;
   logic [79:0]  data5;
   logic [7:0]   val8;
   logic [4:0]   val5;
   int           n_checks = 0;
   int           n_fail = 0;
   logic         m_v [2][8];
   logic [15:0]  m_d [2][8];
   logic         m_err [2];

   always #5 clk = ~clk;

   demux16_router #(.WIDTH(16), .NOUT(8), .SELW(3)) dut (
      .clk(clk), .rst_n(rst_n), .i_in_data(tb_data), .i_in_sel(tb_sel), .i_in_valid(tb_valid),
`ifdef DEMUX16_BROADCAST_EN
      .i_in_bcast(tb_bcast),
`endif
      .o_in_ready(rdy8), .o_out_data(data8), .o_out_valid(val8), .i_out_ready(tb_ordy),
      .o_err_sel(err8));

   demux16_router #(.WIDTH(16), .NOUT(5), .SELW(3)) dut5 (
      .clk(clk), .rst_n(rst_n), .i_in_data(tb_data), .i_in_sel(tb_sel), .i_in_valid(tb_valid),
`ifdef DEMUX16_BROADCAST_EN
      .i_in_bcast(tb_bcast),
`endif
      .o_in_ready(rdy5), .o_out_data(data5), .o_out_valid(val5), .i_out_ready(tb_ordy[4:0]),
      .o_err_sel(err5));

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int u = 0; u < 2; u++) begin
         m_err[u] = 1'b0;
         for (int k = 0; k < 8; k++) begin
            m_v[u][k] = 1'b0;
            m_d[u][k] = '0;
         end
      end
   endtask

   task automatic check_state();
      logic [7:0]   ev8, ev5;
      logic [127:0] ed8, ed5;
      ev8 = '0; ev5 = '0; ed8 = '0; ed5 = '0;
      for (int k = 0; k < 8; k++) begin
         ev8[k] = m_v[0][k];
         ed8[k*16 +: 16] = m_d[0][k];
      end
      for (int k = 0; k < 5; k++) begin
         ev5[k] = m_v[1][k];
         ed5[k*16 +: 16] = m_d[1][k];
      end
      check("valid8", 128'(val8), 128'(ev8));
      check("data8", data8, ed8);
      check("err8", 128'(err8), 128'(m_err[0]));
      check("valid5", 128'(val5), 128'(ev5));
      check("data5", 128'(data5), ed5);
      check("err5", 128'(err5), 128'(m_err[1]));
   endtask

   // One clock of traffic: check ready before the edge, update the model, check slots after it.
   task automatic step(input logic [15:0] d, input logic [2:0] s, input logic v,
                       input logic [7:0] ordy, input logic b);
      logic exp_rdy, acc, all_ok;
      int   n;
      tb_data = d; tb_sel = s; tb_valid = v; tb_ordy = ordy; tb_bcast = b;
      #1;
      for (int u = 0; u < 2; u++) begin
         n = (u == 1) ? 5 : 8;
         all_ok = 1'b1;
         for (int k = 0; k < n; k++) if (m_v[u][k] && !ordy[k]) all_ok = 1'b0;
         exp_rdy = b ? all_ok : (int'(s) >= n) ? 1'b1 : (!m_v[u][s] || ordy[s]);
         check((u == 1) ? "ready5" : "ready8", 128'((u == 1) ? rdy5 : rdy8), 128'(exp_rdy));
         acc = v && exp_rdy;
         m_err[u] = acc && !b && int'(s) >= n;
         for (int k = 0; k < n; k++) begin
            if (m_v[u][k] && ordy[k]) m_v[u][k] = 1'b0;
            if (acc && (b || int'(s) == k)) begin
               m_v[u][k] = 1'b1;
               m_d[u][k] = d;
            end
         end
      end
      @(posedge clk);
      #1;
      check_state();
   endtask

   task automatic rand_steps(input int cnt);
      logic b;
      for (int i = 0; i < cnt; i++) begin
         b = 1'b0;
`ifdef DEMUX16_BROADCAST_EN
         b = ($urandom_range(0, 7) == 0);
`endif
         step(16'($urandom), 3'($urandom), 1'($urandom_range(0, 3) != 0), 8'($urandom), b);
      end
   endtask

   initial begin
      model_clear();
      #12 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("reset_ready8", 128'(rdy8), 128'(1));
      check_state();
      // unicast routing with consumers stalled
      step(16'hA5A5, 3'd3, 1'b1, 8'h00, 1'b0);
      step(16'h1234, 3'd6, 1'b1, 8'h00, 1'b0);
      check("route_valid", 128'(val8), 128'(8'b0100_1000));
      check("route_ch3", 128'(data8[3*16 +: 16]), 128'(16'hA5A5));
      check("route_ch6", 128'(data8[6*16 +: 16]), 128'(16'h1234));
      // backpressure then release with same-cycle pop+push
      step(16'hBEEF, 3'd3, 1'b1, 8'h00, 1'b0);
      check("bp_held_ch3", 128'(data8[3*16 +: 16]), 128'(16'hA5A5));
      step(16'hBEEF, 3'd3, 1'b1, 8'h08, 1'b0);
      check("bp_reload_ch3", 128'(data8[3*16 +: 16]), 128'(16'hBEEF));
      check("bp_valid3", 128'(val8[3]), 128'(1));
      // streaming to channel 1
      for (int i = 0; i < 10; i++) begin
         step(16'(16'h0100 + i), 3'd1, 1'b1, 8'hFF, 1'b0);
         check("stream_ch1", 128'(data8[16 +: 16]), 128'(16'h0100 + i));
      end
      // out-of-range select on the 5-channel instance
      step(16'hDEAD, 3'd6, 1'b1, 8'hFF, 1'b0);
      check("oor_err5", 128'(err5), 128'(1));
      check("oor_valid5", 128'(val5), 128'(0));
      step(16'h0000, 3'd0, 1'b0, 8'hFF, 1'b0);
      check("oor_err5_pulse", 128'(err5), 128'(0));
`ifdef DEMUX16_BROADCAST_EN
      step(16'h00FF, 3'd0, 1'b1, 8'h00, 1'b1);
      check("bcast_valid", 128'(val8), 128'(8'hFF));
      check("bcast_data", data8, {8{16'h00FF}});
      step(16'h1111, 3'd0, 1'b1, 8'hEF, 1'b1);
      step(16'h2222, 3'd4, 1'b1, 8'h00, 1'b0);
      step(16'h3333, 3'd0, 1'b1, 8'h00, 1'b1);
`endif
      rand_steps(400);
      // mid-stream reset with slots 2 and 5 full
      step(16'h2222, 3'd2, 1'b1, 8'h00, 1'b0);
      step(16'h5555, 3'd5, 1'b1, 8'h00, 1'b0);
      tb_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      model_clear();
      check("rst_valid8", 128'(val8), 128'(0));
      check("rst_data8", data8, 128'(0));
      check("rst_err8", 128'(err8), 128'(0));
      check("rst_valid5", 128'(val5), 128'(0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_ready8", 128'(rdy8), 128'(1));
      check("rst_ready5", 128'(rdy5), 128'(1));
      rand_steps(400);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
